// File: rtl/lvds_host.sv
// lvds_host: host endpoint of the 2-bit/cycle LVDS link; sends 58-bit command frames, receives 33-bit response frames.
// Optional response calibration check enabled by defining LVDS_HOST_CAL_CHECK_EN.
module lvds_host #(
  parameter int TINV    = 0,
  parameter int RINV    = 0,
  parameter int TIMEOUT = 255,
  parameter int GAP     = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [1:0]  txd,
  input  logic [1:0]  rxd,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [55:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        rsp_cal_err
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAPS} state_t;
  localparam logic [15:0] TO = 16'(TIMEOUT);
  localparam logic [16:0] GL = 17'(GAP);
  state_t      state, nxt;
  logic [57:0] sr;
  logic [30:0] rsr;
  logic [15:0] cnt;
  logic        lane1;
  logic [1:0]  rx;
  logic        start, tmo_done, rx_done;
  logic [31:0] rword;
  assign rx       = rxd ^ (RINV != 0 ? 2'b11 : 2'b00);
  assign start    = rx != 2'b11;
  assign tmo_done = state == WAIT && !start && cnt == TO;
  assign rx_done  = state == RECV && cnt == 16'd15;
  // rsr keeps the last 31 bits seen; the final cycle's bits complete the word
  assign rword    = lane1 ? {rsr[29:0], rx[0], rx[1]} : {rsr[30:0], rx[0]};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (cmd_valid) nxt = SEND;
      SEND: if (cnt == 16'd28) nxt = WAIT;
      WAIT: if (start) nxt = RECV; else if (cnt == TO) nxt = GAPS;
      RECV: if (cnt == 16'd15) nxt = GAPS;
      GAPS: if (17'(cnt) + 17'd1 >= GL) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = reset_n && state == IDLE;
    txd       = (state == SEND ? {sr[56], sr[57]} : 2'b11) ^ (TINV != 0 ? 2'b11 : 2'b00);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sr          <= '0;
      rsr         <= '0;
      cnt         <= '0;
      lane1       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      cnt       <= nxt != state ? 16'd0 : cnt + 16'd1;
      sr        <= state == IDLE ? {1'b0, cmd_data, 1'b1} : {sr[55:0], 2'b11};
      rsr       <= {rsr[28:0], rx[0], rx[1]};
      rsp_valid <= tmo_done || rx_done;
      if (state == WAIT && start) lane1 <= rx[0];
      if (tmo_done) begin
        rsp_data    <= '0;
        rsp_timeout <= 1'b1;
      end
      if (rx_done) begin
        rsp_data    <= rword;
        rsp_timeout <= 1'b0;
      end
    end
`ifdef LVDS_HOST_CAL_CHECK_EN
  logic        cal;
  logic [31:0] cexp;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cal         <= 1'b0;
      cexp        <= '0;
      rsp_cal_err <= 1'b0;
    end else begin
      if (state == IDLE) begin
        cal  <= cmd_data[55:48] == 8'h00;
        cexp <= cmd_data[40] ? cmd_data[31:0] : 32'h080FF010;
      end
      if (tmo_done) rsp_cal_err <= cal;
      if (rx_done) rsp_cal_err <= cal && rword != cexp;
    end
`else
  assign rsp_cal_err = 1'b0;
`endif
endmodule

// File: tb/tb_lvds_host.sv
// tb_lvds_host: directed self-checking bench for lvds_host (TIMEOUT=20, GAP=4).
module tb_lvds_host;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  txd;
  logic [1:0]  rxd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [55:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        rsp_cal_err;
  int          total = 0;
  int          passed = 0;
  logic        seen;

  lvds_host #(.TINV(0), .RINV(0), .TIMEOUT(20), .GAP(4)) dut (
    .clock(clock), .reset_n(reset_n), .txd(txd), .rxd(rxd),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .rsp_cal_err(rsp_cal_err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // handshake, then check all 29 frame cycles; returns in the first WAIT cycle
  task automatic send_cmd(input logic [55:0] c, input bit hold);
    logic [57:0] f;
    f = {1'b0, c, 1'b1};
    cmd_data = c;
    cmd_valid = 1'b1;
    tick();
    if (!hold) cmd_valid = 1'b0;
    chk("ready_low_in_send", cmd_ready, 1'b0);
    for (int k = 0; k < 29; k++) begin
      chk($sformatf("txd_frame_%0d", k), txd, {f[56-2*k], f[57-2*k]});
      tick();
    end
    chk("txd_idle_after_frame", txd, 2'b11);
  endtask

  // drive a response frame after pre idle cycles; returns in the rsp_valid cycle
  task automatic do_rsp(input logic [31:0] d, input bit lane1, input int pre, input bit cal_exp);
    logic [33:0] v;
    v = lane1 ? {1'b1, 1'b0, d} : {1'b0, d, 1'b1};
    repeat (pre) tick();
    for (int j = 0; j < 17; j++) begin
      rxd = {v[32-2*j], v[33-2*j]};
      tick();
      if (j < 16) chk("no_early_valid", rsp_valid, 1'b0);
    end
    rxd = 2'b11;
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_data", rsp_data, d);
    chk("rsp_timeout", rsp_timeout, 1'b0);
    chk("rsp_cal_err", rsp_cal_err, cal_exp);
  endtask

  task automatic finish_gap(input logic [31:0] d);
    chk("ready_low_gap0", cmd_ready, 1'b0);
    tick();
    chk("valid_pulse_ends", rsp_valid, 1'b0);
    chk("rsp_data_held", rsp_data, d);
    tick();
    tick();
    chk("ready_low_gap3", cmd_ready, 1'b0);
    tick();
    chk("ready_back", cmd_ready, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    rxd = 2'b11;
    cmd_valid = 1'b0;
    cmd_data = '0;
    #3;
    chk("rst_txd", txd, 2'b11);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_timeout", rsp_timeout, 1'b0);
    chk("rst_cal_err", rsp_cal_err, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("idle_ready", cmd_ready, 1'b1);
    tick();

    send_cmd(56'h12_3456_789A_BCDE, 1'b0);
    do_rsp(32'hDEADBEEF, 1'b0, 2, 1'b0);
    finish_gap(32'hDEADBEEF);

    send_cmd(56'h12_3456_789A_BCDE, 1'b0);
    do_rsp(32'hDEADBEEF, 1'b1, 0, 1'b0);
    finish_gap(32'hDEADBEEF);

    send_cmd(56'h77_0000_0000_0001, 1'b0);
    repeat (20) tick();
    chk("tmo_not_yet", rsp_valid, 1'b0);
    tick();
    chk("tmo_valid", rsp_valid, 1'b1);
    chk("tmo_flag", rsp_timeout, 1'b1);
    chk("tmo_data", rsp_data, 32'h0);
    chk("tmo_cal_err", rsp_cal_err, 1'b0);
    finish_gap(32'h0);

    send_cmd(56'hF0_0F55_AA33_CC01, 1'b1);
    do_rsp(32'h1234_5678, 1'b1, 3, 1'b0);
    chk("b2b_ready_low", cmd_ready, 1'b0);
    repeat (4) tick();
    chk("b2b_txd_idle_at_gap_end", txd, 2'b11);
    chk("b2b_ready", cmd_ready, 1'b1);
    tick();
    chk("b2b_start", txd, 2'b10);
    cmd_valid = 1'b0;

    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_txd", txd, 2'b11);
    chk("midrst_ready", cmd_ready, 1'b0);
    tick();
    reset_n = 1'b1;
    rxd = 2'b00;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("midrst_no_valid", seen, 1'b0);
    chk("midrst_ready", cmd_ready, 1'b1);
    rxd = 2'b11;
    tick();
    send_cmd(56'hA1_B2C3_D4E5_F607, 1'b0);
    do_rsp(32'hCAFE_F00D, 1'b0, 1, 1'b0);
    finish_gap(32'hCAFE_F00D);

`ifdef LVDS_HOST_CAL_CHECK_EN
    send_cmd(56'h00_0000_0000_0000, 1'b0);
    do_rsp(32'h080FF010, 1'b0, 1, 1'b0);
    finish_gap(32'h080FF010);
    send_cmd(56'h00_0000_0000_0000, 1'b0);
    do_rsp(32'h080FF011, 1'b1, 1, 1'b1);
    finish_gap(32'h080FF011);
    send_cmd(56'h0001_00A5_A5A5_A5, 1'b0);
    do_rsp(32'hA5A5A5A5, 1'b0, 0, 1'b0);
    finish_gap(32'hA5A5A5A5);
    send_cmd(56'h00_0000_0000_0000, 1'b0);
    repeat (21) tick();
    chk("cal_tmo_valid", rsp_valid, 1'b1);
    chk("cal_tmo_err", rsp_cal_err, 1'b1);
    finish_gap(32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
